operand_rr_sched: RTL and testbench

- Shares one registered 8-bit operand path between two requesters, P and Q. Each requester has a valid/ready handshake.
- Each cycle the block picks at most one requester using round-robin with a burst limit. It drives the internal select and latches the winning operand into a single output register.
- The output register has a valid/ready handshake toward the ALU datapath. The block sits in front of the ALU operand input.

---
 rtl/operand_rr_sched_pkg.sv | 21 ++
 rtl/operand_rr_sched_if.sv | 34 +++
 rtl/operand_rr_sched_rr_arb2_burst.sv | 38 +++
 rtl/operand_rr_sched.sv | 93 +++++++++
 tb/tb_operand_rr_sched.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_rr_sched_pkg.sv
// ---------------------------------------------------------------------------
// operand_rr_sched_pkg
// Shared constants for the operand round-robin scheduler:
//   - src_t        : identifies a requester (P or Q)
//   - SRC_P/SRC_Q  : requester encodings, also used on out_src
//   - ST_IDLE/BUSY : output register state encoding
//   - OPERAND_WIDTH: default operand width
// ---------------------------------------------------------------------------
package operand_rr_sched_pkg;

    typedef logic src_t;

    localparam src_t SRC_P = 1'b0;
    localparam src_t SRC_Q = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int OPERAND_WIDTH = 8;

endpackage

// File: rtl/operand_rr_sched_if.sv
// ---------------------------------------------------------------------------
// operand_rr_sched_if
// Bundles the two requester handshakes and the output handshake.
//   p_valid/p_data/p_ready : requester P
//   q_valid/q_data/q_ready : requester Q
//   out_valid/out_data/out_src/out_ready : registered operand toward the ALU
// Modports:
//   slave  : the scheduler itself
//   master : the environment (requesters plus consumer)
// ---------------------------------------------------------------------------
interface operand_rr_sched_if #(parameter int WIDTH = 8);

    logic             p_valid;
    logic [WIDTH-1:0] p_data;
    logic             p_ready;
    logic             q_valid;
    logic [WIDTH-1:0] q_data;
    logic             q_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport slave (
        input  p_valid, p_data, q_valid, q_data, out_ready,
        output p_ready, q_ready, out_valid, out_data, out_src
    );

    modport master (
        output p_valid, p_data, q_valid, q_data, out_ready,
        input  p_ready, q_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/operand_rr_sched_rr_arb2_burst.sv
// ---------------------------------------------------------------------------
// rr_arb2_burst
// Purely combinational two-way grant decision with a burst limit.
//   p_valid, q_valid : requests
//   last_grant       : requester that won the most recent accept
//   burst_cnt        : consecutive accepts already given to last_grant
//   grant_valid      : some requester wins this cycle
//   grant            : the winner (SRC_P / SRC_Q)
// ---------------------------------------------------------------------------
module rr_arb2_burst
    import operand_rr_sched_pkg::*;
#(
    parameter int BURST = 1,
    parameter int CW    = 4
) (
    input  logic          p_valid,
    input  logic          q_valid,
    input  src_t          last_grant,
    input  logic [CW-1:0] burst_cnt,
    output logic          grant_valid,
    output src_t          grant
);

    localparam logic [CW-1:0] BURST_LIM = CW'(BURST);

    // A lone requester always wins. When both ask, the previous winner keeps
    // the path until it has used its burst, then the other side gets a turn.
    always_comb begin
        grant_valid = p_valid || q_valid;
        grant       = SRC_P;
        if (p_valid && q_valid) begin
            grant = (burst_cnt < BURST_LIM) ? last_grant : ~last_grant;
        end else if (q_valid) begin
            grant = SRC_Q;
        end
    end

endmodule

// File: rtl/operand_rr_sched.sv
// ---------------------------------------------------------------------------
// operand_rr_sched
// Shares one registered operand path between requesters P and Q using
// round-robin arbitration with a burst limit.
//   clk : system clock, all logic on posedge
//   rst : synchronous reset, active-high
//   bus : operand_rr_sched_if.slave (requester and output handshakes)
// Parameters: WIDTH operand width, BURST max consecutive contested grants,
// CW burst counter width (2^CW > BURST).
// ---------------------------------------------------------------------------
module operand_rr_sched
    import operand_rr_sched_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH,
    parameter int BURST = 1,
    parameter int CW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    operand_rr_sched_if.slave   bus
);

    localparam logic [CW-1:0] BURST_LIM = CW'(BURST);

    logic [0:0]       state;
    logic [WIDTH-1:0] out_data_r;
    src_t             out_src_r;
    src_t             last_grant;
    logic [CW-1:0]    burst_cnt;

    logic             load;
    logic             grant_valid;
    src_t             grant;
    logic             accept;

    rr_arb2_burst #(
        .BURST (BURST),
        .CW    (CW)
    ) u_arb (
        .p_valid     (bus.p_valid),
        .q_valid     (bus.q_valid),
        .last_grant  (last_grant),
        .burst_cnt   (burst_cnt),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // The register can take a new operand whenever it is empty or its current
    // contents leave this cycle, giving back-to-back throughput. Readies are
    // suppressed during reset because the register is being cleared and would
    // drop whatever was handed over.
    always_comb begin
        load   = (state == ST_IDLE) || bus.out_ready;
        accept = !rst && load && grant_valid;
    end

    assign bus.p_ready   = accept && (grant == SRC_P);
    assign bus.q_ready   = accept && (grant == SRC_Q);
    assign bus.out_valid = (state == ST_BUSY);
    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;

    // Output register, FSM and fairness bookkeeping. A load without a winner
    // empties the register but keeps the stale data/source visible. The burst
    // counter also counts uncontested accepts, so a requester that has been
    // running alone yields as soon as the other one shows up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            out_data_r <= '0;
            out_src_r  <= SRC_P;
            last_grant <= SRC_Q;
            burst_cnt  <= BURST_LIM;
        end else if (load) begin
            if (grant_valid) begin
                state      <= ST_BUSY;
                out_data_r <= (grant == SRC_Q) ? bus.q_data : bus.p_data;
                out_src_r  <= grant;
                if (grant == last_grant) begin
                    if (burst_cnt < BURST_LIM) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end else begin
                    burst_cnt  <= CW'(1);
                    last_grant <= grant;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_operand_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_operand_rr_sched
// Drives two scheduler instances (BURST = 1 and BURST = 3) with identical
// directed stimulus. A history-based model predicts every output each cycle;
// directed literal checks pin the expected grant sequences.
// ---------------------------------------------------------------------------
module tb_operand_rr_sched;
    import operand_rr_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pv  = 1'b0;
    logic       qv  = 1'b0;
    logic [7:0] pd  = 8'h00;
    logic [7:0] qd  = 8'h00;
    logic       ordy = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_rr_sched_if #(.WIDTH(8)) bus1 ();
    operand_rr_sched_if #(.WIDTH(8)) bus3 ();

    assign bus1.p_valid   = pv;
    assign bus1.p_data    = pd;
    assign bus1.q_valid   = qv;
    assign bus1.q_data    = qd;
    assign bus1.out_ready = ordy;
    assign bus3.p_valid   = pv;
    assign bus3.p_data    = pd;
    assign bus3.q_valid   = qv;
    assign bus3.q_data    = qd;
    assign bus3.out_ready = ordy;

    operand_rr_sched #(.WIDTH(8), .BURST(1), .CW(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    operand_rr_sched #(.WIDTH(8), .BURST(3), .CW(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // Model: each instance keeps a history of granted sources. The length of
    // the trailing run of identical grants decides contested cycles.
    bit         started = 1'b0;
    bit         m_valid [2];
    logic [7:0] m_data  [2];
    bit         m_src   [2];
    bit         hist0 [$];
    bit         hist1 [$];
    int         burst_of [2] = '{1, 3};

    function automatic int run_len(input bit h [$]);
        int n = 0;
        for (int k = h.size() - 1; k >= 0; k--) begin
            if (h[k] == h[h.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    // Returns {grant_valid, grant}
    function automatic bit [1:0] model_grant(input bit p, input bit q,
                                             input bit h [$], input int b);
        bit owner;
        if (!p && !q) return 2'b00;
        if (p && !q)  return 2'b10;
        if (q && !p)  return 2'b11;
        owner = h[h.size() - 1];
        if (run_len(h) < b) return {1'b1, owner};
        return {1'b1, ~owner};
    endfunction

    function automatic bit [1:0] grant_of(input int i);
        if (i == 0) return model_grant(pv, qv, hist0, burst_of[0]);
        return model_grant(pv, qv, hist1, burst_of[1]);
    endfunction

    // Reset history: the Q side is treated as having used its full burst,
    // so P wins the first contested cycle.
    always @(posedge clk) begin : model_blk
        bit [1:0] g;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_valid[i] = 1'b0;
                m_data[i]  = 8'h00;
                m_src[i]   = 1'b0;
                if (i == 0) begin
                    hist0.delete();
                    for (int k = 0; k < burst_of[0]; k++) hist0.push_back(SRC_Q);
                end else begin
                    hist1.delete();
                    for (int k = 0; k < burst_of[1]; k++) hist1.push_back(SRC_Q);
                end
            end else if (!m_valid[i] || ordy) begin
                g = grant_of(i);
                if (g[1]) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = g[0] ? qd : pd;
                    m_src[i]   = g[0];
                    if (i == 0) begin
                        hist0.push_back(g[0]);
                        if (hist0.size() > 8) void'(hist0.pop_front());
                    end else begin
                        hist1.push_back(g[0]);
                        if (hist1.size() > 8) void'(hist1.pop_front());
                    end
                end else begin
                    m_valid[i] = 1'b0;
                end
            end
        end
        if (rst) started = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic compare_inst(input int i, input logic ov, input logic [7:0] od,
                                input logic os, input logic prd, input logic qrd);
        bit [1:0] g;
        bit       acc;
        g   = grant_of(i);
        acc = !rst && (!m_valid[i] || ordy) && g[1];
        checkOutput($sformatf("model%0d.out_valid", i), 32'(ov), 32'(m_valid[i]));
        checkOutput($sformatf("model%0d.out_data", i), 32'(od), 32'(m_data[i]));
        checkOutput($sformatf("model%0d.out_src", i), 32'(os), 32'(m_src[i]));
        checkOutput($sformatf("model%0d.p_ready", i), 32'(prd), 32'(acc && !g[0]));
        checkOutput($sformatf("model%0d.q_ready", i), 32'(qrd), 32'(acc && g[0]));
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            compare_inst(0, bus1.out_valid, bus1.out_data, bus1.out_src,
                         bus1.p_ready, bus1.q_ready);
            compare_inst(1, bus3.out_valid, bus3.out_data, bus3.out_src,
                         bus3.p_ready, bus3.q_ready);
        end
    end

    // Inputs change just after the edge; the task returns at the following
    // falling edge so callers can check the settled outputs.
    task automatic applyStimulus(input logic r, input logic p, input logic [7:0] pdat,
                                 input logic q, input logic [7:0] qdat, input logic o);
        @(posedge clk);
        #1;
        rst  = r;
        pv   = p;
        pd   = pdat;
        qv   = q;
        qd   = qdat;
        ordy = o;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    bit exp1 [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit exp3 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        // Reset, with both requesters already valid: no ready during reset
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(1, 1, 8'h11, 1, 8'h22, 1);
        checkOutput("rst_out_valid", 32'(bus1.out_valid), 0);
        checkOutput("rst_out_data", 32'(bus1.out_data), 0);
        checkOutput("rst_out_src", 32'(bus1.out_src), 0);
        checkOutput("rst_p_ready", 32'(bus1.p_ready), 0);
        checkOutput("rst_q_ready", 32'(bus3.q_ready), 0);

        // Contested stream: strict alternation for BURST=1, runs of 3 for BURST=3
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 8'h11, 1, 8'h22, 1);
            if (k == 0) begin
                checkOutput("first_contest_p_ready", 32'(bus1.p_ready), 1);
                checkOutput("first_out_valid", 32'(bus1.out_valid), 0);
            end else begin
                checkOutput($sformatf("b1_src_%0d", k), 32'(bus1.out_src), 32'(exp1[k-1]));
                checkOutput($sformatf("b1_data_%0d", k), 32'(bus1.out_data),
                            exp1[k-1] ? 32'h22 : 32'h11);
                checkOutput($sformatf("b1_valid_%0d", k), 32'(bus1.out_valid), 1);
                checkOutput($sformatf("b3_src_%0d", k), 32'(bus3.out_src), 32'(exp3[k-1]));
            end
        end

        // Only Q for 5 cycles, then P arrives and wins immediately
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 8'h00, 1, 8'hA5, 1);
            checkOutput($sformatf("q_only_ready_%0d", k), 32'(bus1.q_ready), 1);
        end
        applyStimulus(0, 1, 8'h11, 1, 8'hA5, 1);
        checkOutput("p_after_q_run_b1", 32'(bus1.p_ready), 1);
        checkOutput("p_after_q_run_b3", 32'(bus3.p_ready), 1);
        checkOutput("q_run_data", 32'(bus1.out_data), 32'hA5);

        // Stall with 3C held for 4 cycles
        applyStimulus(0, 1, 8'h3C, 0, 8'h00, 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 8'h00, 1, 8'h44, 0);
            checkOutput($sformatf("stall_data_%0d", k), 32'(bus1.out_data), 32'h3C);
            checkOutput($sformatf("stall_p_ready_%0d", k), 32'(bus1.p_ready), 0);
            checkOutput($sformatf("stall_q_ready_%0d", k), 32'(bus1.q_ready), 0);
        end
        applyStimulus(0, 0, 8'h00, 1, 8'h44, 1);
        checkOutput("unstall_q_ready", 32'(bus1.q_ready), 1);
        checkOutput("unstall_old_data", 32'(bus1.out_data), 32'h3C);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("unstall_new_data", 32'(bus1.out_data), 32'h44);
        checkOutput("unstall_valid", 32'(bus1.out_valid), 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("drain_valid", 32'(bus1.out_valid), 0);
        checkOutput("drain_data_hold", 32'(bus1.out_data), 32'h44);

        // Reset while busy with 7E
        applyStimulus(0, 1, 8'h7E, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0);
        checkOutput("busy_7e", 32'(bus1.out_data), 32'h7E);
        applyStimulus(1, 1, 8'h11, 1, 8'h22, 1);
        checkOutput("midrst_p_ready", 32'(bus1.p_ready), 0);
        checkOutput("midrst_q_ready", 32'(bus1.q_ready), 0);
        applyStimulus(0, 1, 8'h11, 1, 8'h22, 1);
        checkOutput("postrst_valid", 32'(bus1.out_valid), 0);
        checkOutput("postrst_data", 32'(bus1.out_data), 0);
        checkOutput("postrst_p_first_b1", 32'(bus1.p_ready), 1);
        checkOutput("postrst_p_first_b3", 32'(bus3.p_ready), 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        checkOutput("postrst_src", 32'(bus1.out_src), 0);
        checkOutput("postrst_data_11", 32'(bus1.out_data), 32'h11);

        // Mixed traffic, checked by the model only
        for (int k = 0; k < 80; k++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 3) != 0));
        end
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
